// File: rtl/aes_pkg.sv
// Shared AES definitions for the key-expansion slice.
//   AES_NR / AES_NK  : round count and key length in 32-bit words (AES-128)
//   AES_KEY_W        : key / round-key width in bits
//   state_t          : key-schedule controller states
//   SBOX, sub_word() : forward S-box and its word-wide application
//   rot_word()       : one-byte left rotation of a word
package aes_pkg;

  localparam int AES_NR    = 10;
  localparam int AES_NK    = 4;
  localparam int AES_KEY_W = 32 * AES_NK;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/rcon.sv
// AES round-constant table.
//   round : round index 1..10 (other values give 0)
//   rc    : round constant byte (top byte of the rcon word)
module rcon (
  input  logic [3:0] round,
  output logic [7:0] rc
);

  always_comb begin
    case (round)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
  end

endmodule

// File: rtl/aes_key_sched.sv
// Iterative AES-128 key expansion: one round key per accepted handshake,
// rounds 0..10, presented on a valid/ready stream.
//   clk, rst          : clock, synchronous active-high reset
//   start, key_in     : load key_in and begin expansion (sampled in IDLE only)
//   busy              : expansion in progress
//   rk_valid/rk_ready : round-key stream handshake
//   rk_round, rk_out  : round index and round key
//   done              : pulse with the acceptance of round 10
//   rd_round, rd_key  : read port of the stored round keys
//                       (only when AES_KEY_STORE_EN is defined)
module aes_key_sched
  import aes_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [AES_KEY_W-1:0] key_in,
  output logic                 busy,
  output logic                 rk_valid,
  input  logic                 rk_ready,
  output logic [3:0]           rk_round,
  output logic [AES_KEY_W-1:0] rk_out,
  output logic                 done
`ifdef AES_KEY_STORE_EN
  ,
  input  logic [3:0]           rd_round,
  output logic [AES_KEY_W-1:0] rd_key
`endif
);

  state_t               state_q, state_d;
  logic [3:0]           round_q;
  logic [AES_KEY_W-1:0] key_q, key_next;
  logic [3:0]           rcon_idx;
  logic [7:0]           rc;
  logic                 accept, last;

  assign accept   = (state_q == RUN) && rk_ready;
  assign last     = (round_q == 4'(AES_NR));
  assign rcon_idx = round_q + 4'd1;   // the key being built is for round+1

  rcon u_rcon (
    .round (rcon_idx),
    .rc    (rc)
  );

  always_comb begin
    logic [31:0] t, n0, n1, n2, n3;
    t  = sub_word(rot_word(key_q[31:0])) ^ {rc, 24'h0};
    n0 = key_q[127:96] ^ t;
    n1 = key_q[95:64]  ^ n0;
    n2 = key_q[63:32]  ^ n1;
    n3 = key_q[31:0]   ^ n2;
    key_next = {n0, n1, n2, n3};
  end

  // NOTE: every output gets a default first so no path through the case
  // leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    busy     = 1'b0;
    rk_valid = 1'b0;
    done     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = RUN;
      end
      RUN: begin
        busy     = 1'b1;
        rk_valid = 1'b1;
        if (rk_ready && last) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge inputs regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      key_q   <= '0;
      round_q <= '0;
    end else if (state_q == IDLE && start) begin
      key_q   <= key_in;
      round_q <= '0;
    end else if (accept && !last) begin
      key_q   <= key_next;
      round_q <= round_q + 4'd1;
    end
  end

  assign rk_out   = key_q;
  assign rk_round = round_q;

`ifdef AES_KEY_STORE_EN
  logic [AES_KEY_W-1:0] store_q [AES_NR+1];

  // NOTE: the key file is reset explicitly because an aborted expansion must
  // not leave key material readable; start alone does not clear it.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i <= AES_NR; i++) store_q[i] <= '0;
    end else if (accept) begin
      store_q[round_q] <= key_q;
    end
  end

  assign rd_key = (rd_round <= 4'(AES_NR)) ? store_q[rd_round] : '0;
`endif

endmodule

// File: doc/aes_key_sched.md
# aes_key_sched

- Iterative AES-128 key-expansion controller: loads a 128-bit cipher key and produces the eleven round keys (rounds 0–10), one per accepted handshake.
- Drives the shared round-constant table and a SubWord S-box lookup.
- Sits between the key-load interface and the round datapath, which consumes round keys through a valid/ready stream.

## Interface
- No parameters. Key length is fixed at 128 bits, with 10 rounds.
- clk  in  1  — the single clock. Reset is synchronous and active-high.
- rst  in  1  — synchronous, active-high reset.
- start  in  1  — begin expansion of key_in. Sampled only in IDLE.
- key_in  in  128  — cipher key. Word 0 is bits [127:96].
- busy  out  1  — expansion in progress.
- rk_valid  out  1  — rk_out/rk_round hold a round key.
- rk_ready  in  1  — consumer accepts the current round key.
- rk_round  out  4  — round index 0..10 of rk_out.
- rk_out  out  128  — round key.
- done  out  1  — one-cycle pulse on acceptance of round 10.
- rd_round  in  4  — read index. Present only with AES_KEY_STORE_EN.
- rd_key  out  128  — stored round key. Present only with AES_KEY_STORE_EN.

## Operation
- FSM states:
  - IDLE: busy=0, rk_valid=0. On start: capture key_in into the working key, set round=0, go to RUN.
  - RUN: rk_valid=1, rk_out=working key, rk_round=round. On rk_valid&&rk_ready:
    - if round<10: working key ← next(working key, round+1), round++, stay in RUN.
    - if round==10: pulse done, go to IDLE.
- next(k, r), with k split into words w0..w3:
  - t = SubWord(RotWord(w3)) ^ rcon(r)
  - n0 = w0^t, n1 = w1^n0, n2 = w2^n1, n3 = w3^n2
  - This is all combinational within one cycle.
- RotWord is a left rotation by one byte.
- rcon(r) comes from the rcon table with r in 1..10. Only its top byte is non-zero.
- start while busy is ignored. key_in is not re-sampled.
- rk_ready while rk_valid=0 has no effect.
- Reset values:
  - busy=0, rk_valid=0, done=0, rk_round=0, rk_out=0.
  - Working key = 0, state = IDLE.
  - Stored keys (if enabled) = 0.
- Reset mid-expansion aborts immediately: no done pulse, and stored keys are cleared.

## Timing
- start high in IDLE at edge T → busy=1, rk_valid=1, rk_round=0, rk_out=key_in from cycle T+1.
- With rk_ready held high: round r is presented in cycle T+1+r. done=1 in cycle T+11. busy=0, rk_valid=0 from T+12.
- Throughput is one round key per cycle; total latency is 11 cycles minimum.
- Backpressure: while rk_valid=1 and rk_ready=0, rk_out and rk_round hold stable indefinitely.
- start may be re-asserted in the cycle after done. That start is accepted because the state is IDLE at that edge.
- done asserts combinationally with the final handshake. It is high only in the cycle where round 10 is accepted.
- busy equals (state==RUN).

## Configuration
- AES_KEY_STORE_EN defined:
  - An 11×128 register file captures each round key on its handshake, at index rk_round.
  - rd_key = file[rd_round] as a combinational read.
  - rd_round > 10 returns 0.
  - Contents persist after done until the next start (not cleared by start) or rst.
- AES_KEY_STORE_EN undefined:
  - rd_round and rd_key ports and the register file are absent.
  - Round keys are available only on the stream.

## Structure
- Shared package `aes_pkg`:
  - S-box as a 256-entry constant, with a sub_word() function.
  - AES_NR = 10, AES_NK = 4.
  - FSM state enum {IDLE, RUN}.
- Sub-module: instantiate the existing `rcon` round-constant block, driven by round+1.
- S-box lookups use the package function; no separate sub-module.

## Test plan
- FIPS-197 A.1 key 2b7e151628aed2a6abf7158809cf4f3c, start, rk_ready=1:
  - round 1 = a0fafe1788542cb123a339392a6c7605
  - round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6
  - done in T+11
- Same key, rk_ready toggled randomly (~50%):
  - identical 11-key sequence
  - rk_out stable while stalled
  - exactly one done
- start pulsed every cycle during RUN → sequence unaffected, no restart; back-to-back start after done restarts at round 0.
- rst asserted after round 5 accepted:
  - next cycle busy=0, rk_valid=0, rk_out=0, no done
  - new start with key 000…0 yields round 1 = 62636363626363636263636362636363
- With AES_KEY_STORE_EN, after the A.1 run:
  - rd_round=0 → 2b7e…4f3c
  - rd_round=10 → d014…0ca6
  - rd_round=15 → 0
- All-ones key ffff…ff → round 1 = e8e9e9e917161616e8e9e9e917161616; round keys match a software model for all 11 rounds.
